shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle shift unit controller for the NovaEdge32 execute stage. It supports four shift/rotate operations with a single 1-bit-per-cycle right-shift datapath. The shared 32-bit bit-reverse stage is applied before and after the right shifts so that left shifts are performed as reverse, shift right, reverse. The block accepts operations from the issue logic over a valid/ready handshake and returns results to writeback over a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, 32, datapath width; must equal 2**SHAMT_W.
- SHAMT_W, 5, shift-amount width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous to clk and active-high.
- kill  input  1  pipeline flush; aborts any operation in flight.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request; high only in IDLE with rst and kill low.
- in_op  input  2  operation: 00 SRL, 01 SRA, 10 SLL, 11 ROR.
- in_a  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  result register.
- busy  output  1  high in every state other than IDLE.

## Operation
- Registers:
  - data (WIDTH bits), driven on out_result.
  - cnt (SHAMT_W bits).
  - op (2 bits).
  - state, one of IDLE, REV_IN, SHIFT, REV_OUT, DONE.
- Accept: an accept occurs when in_valid && in_ready at a rising edge.
  - On accept, data<=in_a, cnt<=in_shamt, op<=in_op.
  - Next state: SLL goes to REV_IN. Otherwise, in_shamt==0 goes to DONE, else SHIFT.
- REV_IN: data<=bitreverse(data), meaning bit i moves to bit WIDTH-1-i. Next state is REV_OUT if cnt==0, else SHIFT.
- SHIFT: each cycle data<={fill, data[WIDTH-1:1]} and cnt<=cnt-1. When cnt==1, next state is REV_OUT for SLL, else DONE.
- Fill bit by operation:
  - SRL and SLL: 0.
  - SRA: data[WIDTH-1].
  - ROR: data[0].
- REV_OUT: data<=bitreverse(data); next state DONE.
- DONE: out_valid=1. When out_ready is high, next state is IDLE.
- Holding and ignoring inputs:
  - out_result and out_valid hold stable while out_valid && !out_ready.
  - in_a, in_op and in_shamt are ignored outside an accept.
- kill: takes effect at the next edge in any state. It forces state<=IDLE and out_valid low, and leaves data unchanged.
  - kill in DONE while out_ready is high: the result is dropped and no handshake is counted.
  - kill in IDLE with in_valid high: no accept occurs, because in_ready is low.
- rst: has priority over kill and over everything else. It takes effect at the next edge, including in the middle of an operation.
  - state<=IDLE, data<=0, cnt<=0, op<=0.
- Reset values: out_valid 0, out_result 0, busy 0. in_ready is 0 while rst is high and 1 on the first cycle after rst deasserts.

## Timing
- Latency counts edges from the accept edge to the first cycle in which out_valid is high:
  - SRL, SRA, ROR: shamt+1; shamt=0 gives 1.
  - SLL: shamt+3; shamt=0 gives 3.
- Throughput: one operation per (latency+1) cycles when out_ready is held high. DONE lasts at least one cycle, then IDLE lasts at least one cycle.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. in_ready, out_valid and busy decode from state (and rst/kill for in_ready) only.
- shamt wraps are impossible: cnt never decrements below 0, because SHIFT is entered only with cnt≥1.

## Test plan
- SLL: in_a=0x0000_0001, in_shamt=4 -> out_result=0x0000_0010; out_valid in cycle 7 after accept; states IDLE→REV_IN→SHIFT×4→REV_OUT→DONE.
- SRA: in_a=0x8000_0000, in_shamt=31 -> 0xFFFF_FFFF at latency 32. SRL with the same inputs -> 0x0000_0001.
- ROR: in_a=0x0000_0001, in_shamt=1 -> 0x8000_0000 at latency 2. SRL in_a=0xDEAD_BEEF, in_shamt=0 -> 0xDEAD_BEEF at latency 1. SLL, shamt=0 -> 0xDEAD_BEEF at latency 3.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - Required: out_result stable and in_ready=0 throughout.
  - A new in_valid with in_a=0x1234_5678 is not accepted.
  - Raise out_ready: IDLE on the next edge, and the queued request is accepted one cycle later.
- kill and rst mid-SHIFT: issue SRL with shamt=20.
  - Assert kill in the 5th SHIFT cycle -> IDLE next edge, out_valid never rises, and the next request completes correctly.
  - Repeat with rst instead of kill -> out_result=0 and busy=0 after the edge.
- Back-to-back: issue 8 random operations with out_ready=1 and compare against a reference model.
  - Required: every accept occurs exactly one cycle after the previous DONE handshake.
  - Required: zero mismatches.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Issue-side and writeback-side valid/ready handshakes of the multi-cycle shift unit.
interface shift_sequencer_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_op;
  logic [WIDTH-1:0]   in_a;
  logic [SHAMT_W-1:0] in_shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_result;

  modport master (
    output in_valid, in_op, in_a, in_shamt, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_a, in_shamt, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle SRL/SRA/SLL/ROR controller: one bit per cycle right shifts,
// with left shifts done as bit-reverse, shift right, bit-reverse.
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill,
  shift_sequencer_if.slave bus,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REV_IN  = 3'd1,
    SHIFT   = 3'd2,
    REV_OUT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [WIDTH-1:0]   data_r;
  logic [SHAMT_W-1:0] cnt_r;
  logic [1:0]         op_r;
  logic               fill_s;
  logic               in_ready_s;

  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  // Bit shifted in at the top for the operation in flight.
  always_comb begin
    fill_s = 1'b0;
    case (op_r)
      OP_SRA:  fill_s = data_r[WIDTH-1];
      OP_ROR:  fill_s = data_r[0];
      OP_SRL:  fill_s = 1'b0;
      default: fill_s = 1'b0;
    endcase
  end

  assign in_ready_s     = (state_r == IDLE) && !rst && !kill;
  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = (state_r == DONE);
  assign bus.out_result = data_r;
  assign busy           = (state_r != IDLE);

  // Sequencer state, operand register and remaining-shift counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      data_r  <= {WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
      op_r    <= OP_SRL;
    end else if (kill) begin
      // Flush drops the operation but leaves the datapath contents as they are.
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_s) begin
            data_r <= bus.in_a;
            cnt_r  <= bus.in_shamt;
            op_r   <= bus.in_op;
            if (bus.in_op == OP_SLL) begin
              state_r <= REV_IN;
            end else if (bus.in_shamt == CNT_ZERO) begin
              state_r <= DONE;
            end else begin
              state_r <= SHIFT;
            end
          end
        end
        REV_IN: begin
          data_r  <= bit_reverse(data_r);
          state_r <= (cnt_r == CNT_ZERO) ? REV_OUT : SHIFT;
        end
        SHIFT: begin
          data_r <= {fill_s, data_r[WIDTH-1:1]};
          cnt_r  <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= (op_r == OP_SLL) ? REV_OUT : DONE;
          end
        end
        REV_OUT: begin
          data_r  <= bit_reverse(data_r);
          state_r <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes expected result and
// first-valid cycle; a negedge monitor pops and compares on each out_valid rise.
module tb_shift_sequencer;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic kill = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .kill (kill),
    .bus  (bus),
    .busy (busy)
  );

  int checks  = 0;
  int fails   = 0;
  int cyc     = 0;
  int hs_edge = -100;
  logic prev_v = 1'b0;
  logic [31:0] exp_q[$];
  int          expc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [4:0] sh);
    int s;
    s = int'(sh);
    case (op)
      2'b00:   return a >> s;
      2'b01:   return $signed(a) >>> s;
      2'b10:   return a << s;
      default: return (a >> s) | ((s == 0) ? 32'h0 : (a << (32 - s)));
    endcase
  endfunction

  // Monitor: compare each new result against the scoreboard, log handshakes.
  always @(negedge clk) begin
    logic [31:0] r;
    int c;
    if (bus.out_valid === 1'b1 && prev_v !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(bus.out_valid), 32'h0);
      end else begin
        r = exp_q.pop_front();
        c = expc_q.pop_front();
        chk("result", bus.out_result, r);
        chk("latency", 32'(cyc), 32'(c));
      end
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) hs_edge <= cyc + 1;
    prev_v <= bus.out_valid;
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh,
                      input logic [31:0] exp, input int lat, input bit push,
                      input bit b2b, output int waited);
    int acc;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_shamt = sh;
    bus.in_valid = 1'b1;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      chk("accept_timeout", 32'h0, 32'h1);
      bus.in_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (push) begin
      exp_q.push_back(exp);
      expc_q.push_back(acc + lat - 1);
    end
    if (b2b) chk("b2b_accept", 32'(acc), 32'(hs_edge + 1));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'h1, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [1:0]  ops [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11};
    logic [31:0] as  [8] = '{32'hCAFE_F00D, 32'h8765_4321, 32'h0000_00FF, 32'hA5A5_0F0F,
                             32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1357_9BDF, 32'h0000_0003};
    logic [4:0]  shs [8] = '{5'd7, 5'd12, 5'd31, 5'd16, 5'd1, 5'd0, 5'd31, 5'd2};

    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_a      = 32'h0;
    bus.in_shamt  = 5'd0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_result", bus.out_result, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);

    // Directed operations with hand-computed results and latencies.
    send(2'b10, 32'h0000_0001, 5'd4, 32'h0000_0010, 7, 1'b1, 1'b0, w);
    chk("sll_busy", 32'(busy), 32'h1);
    wait_idle();
    send(2'b01, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32, 1'b1, 1'b0, w); wait_idle();
    send(2'b00, 32'h8000_0000, 5'd31, 32'h0000_0001, 32, 1'b1, 1'b0, w); wait_idle();
    send(2'b11, 32'h0000_0001, 5'd1, 32'h8000_0000, 2, 1'b1, 1'b0, w); wait_idle();
    send(2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, 1'b1, 1'b0, w); wait_idle();
    send(2'b10, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 3, 1'b1, 1'b0, w); wait_idle();

    // Backpressure in DONE with a competing request pending.
    bus.out_ready = 1'b0;
    send(2'b00, 32'h0000_00F0, 5'd4, 32'h0000_000F, 5, 1'b1, 1'b0, w);
    w = 0;
    while (bus.out_valid !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.in_op    = 2'b00;
    bus.in_a     = 32'h1234_5678;
    bus.in_shamt = 5'd0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_result", bus.out_result, 32'h0000_000F);
      chk("bp_out_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", 32'(busy), 32'h0);
    send(2'b00, 32'h1234_5678, 5'd0, 32'h1234_5678, 1, 1'b1, 1'b0, w);
    chk("bp_accept_wait", 32'(w), 32'h0);
    wait_idle();

    // kill in the 5th SHIFT cycle: four shifts done, no result produced.
    send(2'b00, 32'hFFFF_FFFF, 5'd20, 32'h0, 0, 1'b0, 1'b0, w);
    repeat (4) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", 32'(busy), 32'h0);
    chk("kill_out_valid", 32'(bus.out_valid), 32'h0);
    chk("kill_data_held", bus.out_result, 32'h0FFF_FFFF);
    repeat (30) @(negedge clk);
    send(2'b11, 32'h1234_5678, 5'd8, 32'h7812_3456, 9, 1'b1, 1'b0, w);
    wait_idle();

    // rst in the 5th SHIFT cycle.
    send(2'b00, 32'hFFFF_FFFF, 5'd20, 32'h0, 0, 1'b0, 1'b0, w);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_result", bus.out_result, 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_release_ready", 32'(bus.in_ready), 32'h1);

    // Back-to-back stream against the reference model.
    for (int i = 0; i < 8; i++) begin
      send(ops[i], as[i], shs[i], ref_model(ops[i], as[i], shs[i]),
           (ops[i] == 2'b10) ? int'(shs[i]) + 3 : int'(shs[i]) + 1,
           1'b1, (i > 0), w);
    end
    wait_idle();

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
